if_fetch_sequencer: RTL
=======================

// Module: if_fetch_sequencer
// PURPOSE
//  Sequences the IF stage: owns the PC and issues one read per cycle to the
//  synchronous instruction memory (1-cycle read latency). A 2-entry fetch
//  queue absorbs in-flight data while decode stalls. Applies branch redirects
//  and stops fetching at a programmed halt address. Sits between the
//  instruction memory and the IF/ID pipeline register.
// PARAMETERS
//  RESET_PC   32'd0   PC loaded on reset
//  HALT_PC    32'd40  first address never fetched; fetch stops here
//  QDEPTH     2       fetch-queue entries (fixed at 2; other values unsupported)
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   synchronous, active-high
//  imem_addr      out  32  byte address to instruction memory
//  imem_rd_en     out  1   read strobe; data returns next cycle on imem_rdata
//  imem_rdata     in   32  instruction word for previous cycle's request
//  branch_taken   in   1   redirect request from EX (single-cycle pulse)
//  branch_target  in   32  redirect byte address; bits [1:0] ignored
//  stall_flag     in   1   decode not ready; 1 = do not consume head
//  inp_instn      out  32  head-of-queue instruction
//  pc_to_branch   out  32  PC of inp_instn
//  nextpc         out  32  pc_to_branch + 4
//  inst_valid     out  1   head entry valid
//  halted         out  1   halt address reached, queue empty, nothing in flight
// BEHAVIOUR
//  - Reset (sync): pc=RESET_PC, queue empty, in-flight=0, state=FETCH.
//    Outputs after reset edge: imem_rd_en=0, imem_addr=RESET_PC, inst_valid=0,
//    inp_instn=0, pc_to_branch=0, nextpc=4, halted=0.
//    Reset beats every other input on the same edge.
//  - States: FETCH, HALT. FETCH->HALT when pc==HALT_PC (no read issued).
//    HALT->FETCH only on branch_taken. HALT is never left by time alone.
//  - Issue rule (FETCH): imem_rd_en=1 iff pc!=HALT_PC and
//    (count + inflight) < QDEPTH after this cycle's pop; imem_addr=pc.
//    On issue: pc<=pc+4 and inflight<=1.
//    Data arrives next cycle and is pushed with its PC.
//  - Pop: head consumed when inst_valid && !stall_flag.
//    Push and pop on the same edge are both legal; count is unchanged.
//  - Throughput: with stall_flag=0, one instruction per cycle.
//    First inst_valid comes 2 cycles after reset deasserts
//    (issue cycle + memory cycle).
//  - Stall: the queue fills to 2 and then issue stops. No response is ever
//    dropped, and inp_instn/pc_to_branch stay stable while stall_flag=1.
//  - Redirect (branch_taken=1): queue flushed, any in-flight response
//    marked killed (not pushed), pc <= {branch_target[31:2],2'b00},
//    state <= FETCH. A read may issue to the new target in the next cycle
//    only. Redirect beats pop, push and halt detection in the same cycle.
//    Redirect while stall_flag=1 is legal and still flushes.
//  - Arithmetic: PC increments modulo 2^32. Wrap to 0 is not an error,
//    but HALT_PC still stops fetch.
//  - halted = (state==HALT) && count==0 && !inflight; registered.
//  - inp_instn=0 and pc_to_branch=0 whenever inst_valid=0.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//   - adds outputs fetch_cnt[31:0] (reads issued) and stall_cnt[31:0]
//     (cycles with inst_valid && stall_flag).
//   - adds output flush_cnt[31:0] (branch_taken cycles).
//   - all three clear on reset and saturate at 32'hFFFF_FFFF.
//  Not defined: none of these ports or registers exist.
//  All other behaviour is identical either way.
// TESTING
//  1. reset 2 cycles, stall=0, mem[i]=i+100:
//     PCs 0,4,...,36 each valid one cycle, inp_instn=100..109, then halted=1,
//     imem_addr 40 never strobed.
//  2. stall_flag=1 from 3rd valid cycle for 5 cycles:
//     head holds pc=8, queue count=2, imem_rd_en=0;
//     on release pcs 8,12,16 follow back-to-back with no gap or loss.
//  3. branch_taken=1, target=32'h23 while pc=12 in flight:
//     in-flight word dropped, next valid pc=32'h20, nextpc=32'h24.
//  4. Redirect while in HALT (target=0):
//     halted drops next cycle, fetch restarts at 0.
//  5. reset asserted mid-stream with queue full:
//     next cycle inst_valid=0, imem_rd_en=0; fetch resumes at RESET_PC.
//  6. With FETCH_PERF_CNT_EN, run scenario 2:
//     fetch_cnt=10, stall_cnt=5, flush_cnt=0 at halt.

Source files
------------

// File: rtl/if_fetch_sequencer.sv
// if_fetch_sequencer: IF-stage PC owner issuing one imem read per cycle into a 2-entry fetch queue, with redirect and halt-address stop.
// Ports: clk/reset (sync, active-high); imem_addr/imem_rd_en/imem_rdata to a 1-cycle-latency instruction memory;
// branch_taken/branch_target redirect from EX; stall_flag from decode; inp_instn/pc_to_branch/nextpc/inst_valid
// present the queue head to IF/ID; halted flags a drained stop at HALT_PC.
// Build option FETCH_PERF_CNT_EN adds saturating fetch_cnt/stall_cnt/flush_cnt outputs.
module if_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] HALT_PC  = 32'd40,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall_flag,
  output logic [31:0] inp_instn,
  output logic [31:0] pc_to_branch,
  output logic [31:0] nextpc,
  output logic        inst_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  typedef enum logic {FETCH, HALT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, req_pc, head_ins, head_pc, tail_ins, tail_pc;
  logic [1:0] count, cnt_pop, cnt_nx;
  logic inflight, pop, push, halted_nx;
  always_comb begin
    inst_valid   = count != 2'd0;
    inp_instn    = inst_valid ? head_ins : 32'd0;
    pc_to_branch = inst_valid ? head_pc : 32'd0;
    nextpc       = pc_to_branch + 32'd4;
    pop          = inst_valid && !stall_flag && !branch_taken;
    push         = inflight && !branch_taken;
    cnt_pop      = count - {1'b0, pop};
    imem_addr    = pc;
    // occupancy counts the response already in flight so it always has a slot
    imem_rd_en   = !reset && !branch_taken && state == FETCH && pc != HALT_PC &&
                   ({1'b0, cnt_pop} + {2'b0, inflight}) < 3'(QDEPTH);
    cnt_nx       = branch_taken ? 2'd0 : cnt_pop + {1'b0, push};
    state_nx     = branch_taken ? FETCH : (state == FETCH && pc == HALT_PC) ? HALT : state;
    halted_nx    = state_nx == HALT && cnt_nx == 2'd0 && !imem_rd_en;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      req_pc   <= 32'd0;
      count    <= 2'd0;
      inflight <= 1'b0;
      halted   <= 1'b0;
      head_ins <= 32'd0;
      head_pc  <= 32'd0;
      tail_ins <= 32'd0;
      tail_pc  <= 32'd0;
    end else begin
      state    <= state_nx;
      count    <= cnt_nx;
      inflight <= imem_rd_en;
      halted   <= halted_nx;
      if (imem_rd_en) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end
      if (branch_taken) pc <= branch_target & ~32'd3;
      if (pop) begin
        head_ins <= tail_ins;
        head_pc  <= tail_pc;
      end
      if (push && cnt_pop == 2'd0) begin
        head_ins <= imem_rdata;
        head_pc  <= req_pc;
      end
      if (push && cnt_pop != 2'd0) begin
        tail_ins <= imem_rdata;
        tail_pc  <= req_pc;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (imem_rd_en && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
      if (inst_valid && stall_flag && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (branch_taken && flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif
endmodule
